// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit path: FSM state encoding,
// frame-width helper and the idle level of the frame select.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } spi_state_e;

  localparam logic CS_IDLE = 1'b1;

  function automatic int frame_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous FIFO buffering {addr, data} words ahead of the SPI shifter.
// DEPTH must be a power of two >= 2; simultaneous push and pop while full is allowed.
module spi_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI transmit master: serialises {addr, data} words MSB first on cs/mosi.
// Define SPI_TX_FIFO_EN to put a FIFO_DEPTH-entry input FIFO in front of the shifter.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int ADDR_W     = 1,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic [DATA_W-1:0] tx_data,
  output logic              cs,
  output logic              mosi,
  output logic              busy,
  output logic              tx_done,
  output logic [1:0]        dbg_state
);

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
  // tx_addr/tx_data must hold steady until then and are captured only on that edge.

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int GC_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  spi_state_e         state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
  logic [GC_W-1:0]    gapcnt_q, gapcnt_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               tx_done_q, tx_done_d;

  logic               fsm_ready;
  logic               word_avail;
  logic               load;
  logic [FRAME_W-1:0] word;
  logic               unused_cfg;

  assign fsm_ready  = (state_q == IDLE) || ((state_q == GAP) && (gapcnt_q == '0));
  assign load       = word_avail && fsm_ready;
  assign unused_cfg = ^FIFO_DEPTH;

`ifdef SPI_TX_FIFO_EN
  logic               fifo_full, fifo_empty;
  logic [FRAME_W-1:0] fifo_head;

  spi_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk   (sclk),
    .reset (reset),
    .push  (tx_valid && !fifo_full),
    .pop   (load),
    .wdata ({tx_addr, tx_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_ready   = !fifo_full;
  assign word_avail = !fifo_empty;
  assign word       = fifo_head;
`else
  assign tx_ready   = fsm_ready;
  assign word_avail = tx_valid;
  assign word       = {tx_addr, tx_data};
`endif

  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bitcnt_q  <= '0;
      gapcnt_q  <= '0;
      cs_q      <= CS_IDLE;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bitcnt_q  <= bitcnt_d;
      gapcnt_q  <= gapcnt_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (bitcnt_q == '0) state_d = GAP;
      GAP:     if (gapcnt_q == '0) state_d = load ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d      = sr_q;
    bitcnt_d  = bitcnt_q;
    gapcnt_d  = gapcnt_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    tx_done_d = 1'b0;
    if (load) begin
      // The MSB goes out on the load edge itself, so cs is low exactly FRAME_W cycles.
      sr_d     = word;
      cs_d     = 1'b0;
      mosi_d   = word[FRAME_W-1];
      bitcnt_d = BC_W'(FRAME_W - 1);
    end else begin
      case (state_q)
        SHIFT: begin
          if (bitcnt_q != '0) begin
            sr_d     = sr_q << 1;
            mosi_d   = sr_q[FRAME_W-2];
            bitcnt_d = bitcnt_q - 1'b1;
          end else begin
            cs_d      = CS_IDLE;
            mosi_d    = 1'b0;
            tx_done_d = 1'b1;
            gapcnt_d  = GC_W'(GAP_CYCLES - 1);
          end
        end
        GAP: begin
          cs_d = CS_IDLE;
          if (gapcnt_q != '0) gapcnt_d = gapcnt_q - 1'b1;
        end
        default: begin
          cs_d   = CS_IDLE;
          mosi_d = 1'b0;
        end
      endcase
    end
  end

  assign busy_d    = (state_d != IDLE);
  assign cs        = cs_q;
  assign mosi      = mosi_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;
  assign dbg_state = state_q;

endmodule
